vga_pixel_fetch: RTL
====================

Name: vga_pixel_fetch

Overview:
- Read-side companion to the Mandelbrot iterator array. Walks the VGA frame in raster order and issues read addresses to NUM_PARTITIONS iterator-owned 8-bit M10K colour memories.
- Absorbs the one-cycle M10K read latency, selects the owning partition's data, and delivers pixels over a valid/ready stream to the VGA output stage.
- Pixel index p = y*H_ACTIVE + x. Pixel p lives in partition (p mod NUM_PARTITIONS) at local address (p / NUM_PARTITIONS).

Parameters:
NUM_PARTITIONS, 4, number of iterator memories; must be at least 1.
H_ACTIVE, 640, pixels per line.
V_ACTIVE, 480, lines per frame.
PARTITION_SIZE, 76800, words per memory; equals H_ACTIVE*V_ACTIVE/NUM_PARTITIONS, which must be an exact integer.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset (reset==0 resets)
start  in  1  request one frame readout; sampled only in IDLE
m10k_read_address  out  $clog2(PARTITION_SIZE)  local read address, shared by all partitions
m10k_read_data  in  8*NUM_PARTITIONS  concatenated q outputs; partition k at bits [8k+7:8k]; valid 1 cycle after address
pix_valid  out  1  output pixel valid
pix_ready  in  1  downstream accepts pixel
pix_color  out  8  colour of current pixel
pix_x  out  10  column of current pixel
pix_y  out  9  row of current pixel
pix_last  out  1  current pixel is (H_ACTIVE-1, V_ACTIVE-1)
busy  out  1  high in STREAM and DRAIN
frame_done  out  1  one-cycle pulse after the last pixel handshake

Behaviour:
- Reset (reset==0 at a clock edge):
  - All outputs go to 0, including m10k_read_address.
  - Issue counters, in-flight flag and output buffer are cleared.
  - State goes to IDLE.
  - Reset mid-frame aborts the frame with no frame_done.
- States:
  - IDLE: start==1 zeroes the issue counters (x, y, part, local) and moves to STREAM. start is ignored outside IDLE.
  - STREAM: issues reads. Moves to DRAIN in the cycle the final pixel (H_ACTIVE-1, V_ACTIVE-1) is issued.
  - DRAIN: no new issues. Moves to IDLE in the cycle after the handshake on pix_last. frame_done pulses in that IDLE cycle and busy is 0 in it. A start in that same cycle is accepted.
- Issue counters, advanced only on an issue:
  - x wraps at H_ACTIVE-1 to 0; y increments on x wrap.
  - part wraps at NUM_PARTITIONS-1 to 0; local increments on part wrap.
  - No division or multiplication.
  - m10k_read_address = local of the issued pixel.
  - In cycles with no issue, m10k_read_address holds its last value.
- Latency:
  - An issue in cycle t latches {part, x, y, last} into a one-stage in-flight register.
  - In cycle t+1, m10k_read_data[8*part +: 8] is written into the output buffer with the tagged x/y/last.
  - The first pixel_valid after start appears no earlier than 2 cycles after the start cycle.
- Output buffer:
  - 2-entry FIFO driving pix_*.
  - Handshake occurs when pix_valid && pix_ready.
  - pix_color, pix_x, pix_y and pix_last are stable while pix_valid && !pix_ready.
- Issue rule: issue only in STREAM and only when (fifo_count + inflight - pop) < 2, where pop = pix_valid && pix_ready in the current cycle.
  - This never overflows.
  - It sustains 1 pixel/cycle with pix_ready held high.
- Boundaries:
  - With the FIFO full, issue stops; no data is lost because an in-flight read always has a free slot.
  - pix_ready low for any duration stalls without reordering.
  - NUM_PARTITIONS==1: part is always 0 and local equals p.
  - Last pixel: pix_last is asserted only with (H_ACTIVE-1, V_ACTIVE-1).

Test Plan:
- Params N=4, H=8, V=4; memory k preloaded with colour {k[1:0], local[5:0]}. start pulse, pix_ready=1 → 32 pixels on consecutive cycles, in raster order. Pixel p has colour {p%4, p/4}. Address sequence is 0,0,0,0,1,1,1,1,…,7. pix_last on p=31 only; frame_done one cycle after it.
- Same setup, pix_ready toggling 1,0,0,1 repeatedly → same 32-pixel sequence with no drops or duplicates. Outputs hold steady during ready=0. FIFO occupancy never exceeds 2.
- pix_ready=0 from start for 10 cycles → exactly 2 reads issued and pix_valid=1 with pixel (0,0). After ready rises, the stream resumes at (1,0).
- Reset driven low for 1 cycle at pixel 13 → all outputs 0 next cycle, no frame_done. A new start then restarts at (0,0) with address 0.
- start held high continuously → back-to-back frames: start is ignored while busy, a second frame begins in the frame_done cycle, and each frame yields exactly 32 pixels.
- N=1, H=4, V=2 → addresses 0..7 in order; colour equals the memory contents at p.

Source files
------------

// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch: walks the VGA frame in raster order, issues read addresses
// to the partitioned colour memories, absorbs the one-cycle read latency and
// streams the selected colour with its coordinates over a valid/ready port.
module vga_pixel_fetch #(
    parameter int NUM_PARTITIONS = 4,
    parameter int H_ACTIVE       = 640,
    parameter int V_ACTIVE       = 480,
    parameter int PARTITION_SIZE = 76800
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    output logic [$clog2(PARTITION_SIZE)-1:0] m10k_read_address,
    input  logic [8*NUM_PARTITIONS-1:0]       m10k_read_data,
    output logic                              pix_valid,
    input  logic                              pix_ready,
    output logic [7:0]                        pix_color,
    output logic [9:0]                        pix_x,
    output logic [8:0]                        pix_y,
    output logic                              pix_last,
    output logic                              busy,
    output logic                              frame_done
);

    localparam int AW = $clog2(PARTITION_SIZE);
    localparam int PW = (NUM_PARTITIONS > 1) ? $clog2(NUM_PARTITIONS) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    typedef struct packed {
        logic [7:0] color;
        logic [9:0] x;
        logic [8:0] y;
        logic       last;
    } pixel_t;

    state_t state, state_next;

    // Issue counters: position of the next pixel to be read
    logic [9:0]    x_cnt;
    logic [8:0]    y_cnt;
    logic [PW-1:0] part_cnt;
    logic [AW-1:0] local_cnt;

    // One-stage tag register covering the memory read latency
    logic          inflight;
    logic [PW-1:0] inflight_part;
    logic [9:0]    inflight_x;
    logic [8:0]    inflight_y;
    logic          inflight_last;

    // Two-entry output buffer
    pixel_t     fifo_mem [2];
    logic       rd_ptr;
    logic       wr_ptr;
    logic [1:0] fifo_count;

    logic       issue;
    logic       issue_last;
    logic       pop;
    logic       frame_end;
    logic [2:0] occupancy;
    logic [7:0] sel_color;

    assign pop        = pix_valid && pix_ready;
    // Slots already spoken for once this cycle's pop is taken into account;
    // keeping this below 2 guarantees every in-flight read finds a free slot.
    assign occupancy  = 3'(fifo_count) + 3'(inflight) - 3'(pop);
    assign issue_last = (x_cnt == 10'(H_ACTIVE - 1)) && (y_cnt == 9'(V_ACTIVE - 1));

    // State register
    // NOTE: clocked state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, issue decision and end-of-frame detection
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        frame_end  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (occupancy < 3'd2) begin
                    issue = 1'b1;
                    if (issue_last) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && pix_last) begin
                    state_next = IDLE;
                    frame_end  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Raster and partition counters; the final pixel does not advance them,
    // so the address keeps showing the last local word that was read
    always_ff @(posedge clk) begin
        if (!reset) begin
            x_cnt     <= '0;
            y_cnt     <= '0;
            part_cnt  <= '0;
            local_cnt <= '0;
        end else if (state == IDLE && start) begin
            x_cnt     <= '0;
            y_cnt     <= '0;
            part_cnt  <= '0;
            local_cnt <= '0;
        end else if (issue && !issue_last) begin
            if (x_cnt == 10'(H_ACTIVE - 1)) begin
                x_cnt <= '0;
                y_cnt <= y_cnt + 9'd1;
            end else begin
                x_cnt <= x_cnt + 10'd1;
            end
            if (part_cnt == PW'(NUM_PARTITIONS - 1)) begin
                part_cnt  <= '0;
                local_cnt <= local_cnt + AW'(1);
            end else begin
                part_cnt <= part_cnt + PW'(1);
            end
        end
    end

    assign m10k_read_address = local_cnt;

    // Tag the issued read so its data can be routed one cycle later
    always_ff @(posedge clk) begin
        if (!reset) begin
            inflight      <= 1'b0;
            inflight_part <= '0;
            inflight_x    <= '0;
            inflight_y    <= '0;
            inflight_last <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_part <= part_cnt;
                inflight_x    <= x_cnt;
                inflight_y    <= y_cnt;
                inflight_last <= issue_last;
            end
        end
    end

    // Pick the owning partition's byte out of the concatenated read data
    always_comb begin
        sel_color = 8'h00;
        for (int k = 0; k < NUM_PARTITIONS; k++) begin
            if (inflight_part == PW'(k)) begin
                sel_color = m10k_read_data[8*k +: 8];
            end
        end
    end

    // Output buffer: push returning reads, pop on handshake
    // NOTE: the two buffer entries are reset on purpose because they drive
    // the pixel outputs directly and those must read zero after reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                fifo_mem[i] <= '0;
            end
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            fifo_count <= 2'd0;
        end else begin
            if (inflight) begin
                fifo_mem[wr_ptr] <= '{color: sel_color, x: inflight_x,
                                      y: inflight_y, last: inflight_last};
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({inflight, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign pix_valid = (fifo_count != 2'd0);
    assign pix_color = fifo_mem[rd_ptr].color;
    assign pix_x     = fifo_mem[rd_ptr].x;
    assign pix_y     = fifo_mem[rd_ptr].y;
    assign pix_last  = fifo_mem[rd_ptr].last;
    assign busy      = (state != IDLE);

    // Single-cycle pulse in the IDLE cycle following the last handshake
    always_ff @(posedge clk) begin
        if (!reset) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end;
        end
    end

endmodule
